mdio_responder: RTL and testbench
=================================

MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd1, MDIO address this responder answers.
REQ-002 SHALL have parameter PHY_ID1, default 16'h2000, value returned for register 2.
REQ-003 SHALL have parameter PHY_ID2, default 16'h5C90, value returned for register 3.
REQ-004 SHALL have port sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port mdc  input  1  management clock from MAC, asynchronous to sys_clk.
REQ-007 SHALL have port mdio_i  input  1  MDIO line value from IOBUF O.
REQ-008 SHALL have port mdio_o  output  1  value driven onto MDIO (to IOBUF I).
REQ-009 SHALL have port mdio_t  output  1  tristate control, 1 = released (to IOBUF T).
REQ-010 SHALL have port link_up  input  1  link status reflected in register 1 bit 2.
REQ-011 SHALL have port wr_strobe  output  1  one-cycle pulse on accepted register write.
REQ-012 SHALL have port wr_addr  output  5  register address of last accepted write.
REQ-013 SHALL have port wr_data  output  16  data of last accepted write.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on malformed frame addressed to or received by responder.

Function
REQ-015 SHALL synchronise mdc and mdio_i through 2 flops each; mdc rising edge detected from synchronised copy (edge event 3 sys_clk after pin edge); mdio_i sampled only on detected edge.
REQ-016 SHALL operate correctly when mdc high and low phases each >= 4 sys_clk cycles.
REQ-017 SHALL implement Clause 22 frame states: IDLE (preamble hunt), ST, OP, PHYAD, REGAD, TA, DATA.
REQ-018 IDLE: count consecutive sampled 1s (saturating at 32); a 0 sampled with count = 32 -> ST (first ST bit seen); a 0 with count < 32 -> clear count, stay IDLE.
REQ-019 ST: second bit must be 1 -> OP; else frame_err, -> IDLE.
REQ-020 OP: 2 bits; 10 = read, 01 = write; 00/11 -> frame_err, -> IDLE.
REQ-021 PHYAD: 5 bits MSB-first; mismatch with PHY_ADDR -> IDLE silently, count cleared, mdio_t stays 1.
REQ-022 REGAD: 5 bits MSB-first; on read, register value snapshotted at the edge sampling the REGAD LSB.
REQ-023 Read TA: mdio_t stays 1 through first TA bit; at edge sampling TA bit 1, drive mdio_o=0, mdio_t=0.
REQ-024 Read DATA: at each subsequent edge present next data bit, D15 first; at edge sampling D0 position, set mdio_t=1, -> IDLE.
REQ-025 mdio_o/mdio_t SHALL change exactly 1 sys_clk after the detected edge; mdio_t=1 at all other times.
REQ-026 Write: TA bits not checked; 16 data bits shifted MSB-first; after D0 sampled, write applied next cycle, -> IDLE.
REQ-027 Register map: reg0 R/W reset 16'h1140; reg1 RO = 16'h7809 with bit2 = link_up; reg2 RO PHY_ID1; reg3 RO PHY_ID2; reg4 R/W reset 16'h01E1; reg31 R/W reset 16'h0000; all others read 16'h0000.
REQ-028 Write to reg0 with bit15=1 SHALL reload reg0, reg4, reg31 defaults (reg0 bit15 reads 0).
REQ-029 wr_strobe SHALL pulse, with wr_addr/wr_data updated the same cycle, only for writes to reg0/4/31; writes to RO/unimplemented registers ignored, no pulse.
REQ-030 wr_addr/wr_data SHALL hold value between strobes.
REQ-031 Back-to-back frames with 32-bit preamble immediately after previous frame SHALL be accepted.

Reset
REQ-032 rst_n low at a sys_clk edge SHALL force next cycle: state IDLE, preamble count 0, mdio_t=1, mdio_o=0, wr_strobe=0, frame_err=0, wr_addr=0, wr_data=0, registers to defaults, synchroniser flops 0.
REQ-033 Reset asserted mid-read SHALL release MDIO (mdio_t=1) the cycle after assertion; frame abandoned.

Verification
REQ-034 32x1 preamble, read PHYAD=1 REGAD=2 -> mdio_t low from TA bit 2 for 17 bits; bits returned 0, 16'h2000; then mdio_t=1.
REQ-035 Write PHYAD=1 REGAD=31 data 16'hA5C3, then read reg31 -> wr_strobe once, wr_addr=31, wr_data=16'hA5C3; read returns 16'hA5C3.
REQ-036 Read PHYAD=7 -> mdio_t=1 throughout, no frame_err, no wr_strobe; next valid frame answered.
REQ-037 31-bit preamble then ST -> frame ignored; OP=11 after valid preamble -> one frame_err pulse, no drive.
REQ-038 link_up=1, read reg1 -> 16'h780D; toggle link_up to 0 during DATA -> value unchanged for that frame.
REQ-039 Write reg4=16'h0000, then reg0=16'h8000 -> reg4 reads 16'h01E1, reg0 reads 16'h1140; assert rst_n low mid-read -> mdio_t=1 next cycle.

Source files
------------

// File: rtl/mdio_responder.sv
// mdio_responder: Clause 22 MDIO management slave with a small PHY register file, clocked from sys_clk.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter logic [15:0] PHY_ID1  = 16'h2000,
  parameter logic [15:0] PHY_ID2  = 16'h5C90
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        link_up,
  output logic        wr_strobe,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_err
);
  typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, DATA} state_t;
  state_t      state;
  logic [2:0]  mdc_s;
  logic [1:0]  mdio_s;
  logic [5:0]  cnt;
  logic [15:0] sh, r0, r4, r31, rd_val, wd;
  logic [4:0]  ra, sel;
  logic        rd, rise, d, wr_ok;
  assign rise  = mdc_s[1] & ~mdc_s[2];
  assign d     = mdio_s[1];
  assign sel   = {sh[3:0], d};
  assign wd    = {sh[14:0], d};
  assign wr_ok = ra == 5'd0 || ra == 5'd4 || ra == 5'd31;
  // sel is the register address as it completes on the last REGAD bit
  always_comb
    rd_val = sel == 5'd0  ? r0 :
             sel == 5'd1  ? (16'h7809 | {13'd0, link_up, 2'd0}) :
             sel == 5'd2  ? PHY_ID1 :
             sel == 5'd3  ? PHY_ID2 :
             sel == 5'd4  ? r4 :
             sel == 5'd31 ? r31 : 16'h0000;
  always_ff @(posedge sys_clk)
    if (!rst_n) begin
      state     <= IDLE;
      mdc_s     <= '0;
      mdio_s    <= '0;
      cnt       <= '0;
      sh        <= '0;
      ra        <= '0;
      rd        <= 1'b0;
      mdio_o    <= 1'b0;
      mdio_t    <= 1'b1;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_err <= 1'b0;
      r0        <= 16'h1140;
      r4        <= 16'h01E1;
      r31       <= 16'h0000;
    end else begin
      mdc_s     <= {mdc_s[1:0], mdc};
      mdio_s    <= {mdio_s[0], mdio_i};
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (rise) begin
        cnt <= cnt + 6'd1;
        case (state)
          IDLE: begin
            cnt <= d ? (cnt == 6'd32 ? cnt : cnt + 6'd1) : 6'd0;
            if (!d && cnt == 6'd32) state <= ST;
          end
          ST: begin
            cnt       <= 6'd0;
            state     <= d ? OP : IDLE;
            frame_err <= !d;
          end
          OP: begin
            sh <= wd;
            if (cnt[0]) begin
              cnt       <= 6'd0;
              rd        <= sh[0];
              state     <= (sh[0] ^ d) ? PHYAD : IDLE;
              frame_err <= !(sh[0] ^ d);
            end
          end
          PHYAD: begin
            sh <= wd;
            if (cnt == 6'd4) begin
              cnt   <= 6'd0;
              state <= sel == PHY_ADDR ? REGAD : IDLE;
            end
          end
          REGAD: begin
            sh <= wd;
            if (cnt == 6'd4) begin
              cnt   <= 6'd0;
              ra    <= sel;
              state <= TA;
              if (rd) sh <= rd_val;
            end
          end
          TA: begin
            if (cnt[0]) begin
              cnt   <= 6'd0;
              state <= DATA;
            end
            if (rd) begin
              mdio_t <= 1'b0;
              mdio_o <= cnt[0] & sh[15];
              if (cnt[0]) sh <= {sh[14:0], 1'b0};
            end
          end
          DATA: begin
            sh     <= rd ? {sh[14:0], 1'b0} : wd;
            mdio_o <= rd && cnt != 6'd15 && sh[15];
            if (cnt == 6'd15) begin
              cnt    <= 6'd0;
              state  <= IDLE;
              mdio_t <= 1'b1;
              if (!rd) begin
                wr_strobe <= wr_ok;
                if (wr_ok) begin
                  wr_addr <= ra;
                  wr_data <= wd;
                end
                if (ra == 5'd0 && wd[15]) begin
                  r0  <= 16'h1140;
                  r4  <= 16'h01E1;
                  r31 <= 16'h0000;
                end else begin
                  if (ra == 5'd0) r0 <= wd;
                  if (ra == 5'd4) r4 <= wd;
                  if (ra == 5'd31) r31 <= wd;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: MAC-side frame driver with a register-map reference model for mdio_responder.
module tb_mdio_responder;
  localparam logic [4:0]  PA  = 5'd1;
  localparam logic [15:0] ID1 = 16'h2000;
  localparam logic [15:0] ID2 = 16'h5C90;
  logic sys_clk = 1'b0, rst_n = 1'b0, mdc = 1'b0, mac_oe = 1'b0, mac_bit = 1'b1, link_up = 1'b0;
  logic mdio_i, mdio_o, mdio_t, wr_strobe, frame_err;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  int checks = 0, errors = 0, strobes = 0, errs = 0, drives = 0;
  logic [15:0] m [32];
  logic [4:0]  last_wa = '0;
  logic [15:0] last_wd = '0;

  mdio_responder dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o),
    .mdio_t(mdio_t), .link_up(link_up), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_err(frame_err)
  );

  // open-drain style line: MAC drives, else responder drives, else pull-up
  assign mdio_i = mac_oe ? mac_bit : (mdio_t ? 1'b1 : mdio_o);
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (wr_strobe) strobes++;
    if (frame_err) errs++;
    if (!mdio_t) drives++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m[i]) m[i] = 16'h0000;
    m[0] = 16'h1140;
    m[4] = 16'h01E1;
  endtask

  function automatic bit writable(input logic [4:0] a);
    return a == 5'd0 || a == 5'd4 || a == 5'd31;
  endfunction

  function automatic logic [15:0] model_rd(input logic [4:0] a, input logic lk);
    case (a)
      5'd1:    return lk ? 16'h780D : 16'h7809;
      5'd2:    return ID1;
      5'd3:    return ID2;
      default: return writable(a) ? m[a] : 16'h0000;
    endcase
  endfunction

  task automatic frame(input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] wd, input int pre, input bit tog, input int abort);
    bit q[$];
    bit oe_q[$];
    logic t_s[$];
    logic o_s[$];
    bit valid_op, hit, rd, exp_strobe;
    logic [15:0] exp, word;
    logic h1, h4;
    int s0, e0, d0, ndrv, hdr;
    valid_op = op == 2'b10 || op == 2'b01;
    rd  = op == 2'b10;
    hit = pre >= 32 && valid_op && phy == PA;
    exp = model_rd(ra, link_up);
    s0 = strobes; e0 = errs; d0 = drives;
    h1 = 1'bx; h4 = 1'bx; word = '0; ndrv = 0;
    for (int i = 0; i < pre; i++) begin q.push_back(1'b1); oe_q.push_back(1'b1); end
    q.push_back(1'b0); q.push_back(1'b1); q.push_back(op[1]); q.push_back(op[0]);
    for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) q.push_back(ra[i]);
    for (int i = 0; i < 14; i++) oe_q.push_back(1'b1);
    hdr = pre + 14;
    if (rd) begin
      for (int i = 0; i < 18; i++) begin q.push_back(1'b1); oe_q.push_back(1'b0); end
    end else begin
      q.push_back(1'b1); q.push_back(1'b0);
      for (int i = 15; i >= 0; i--) q.push_back(wd[i]);
      for (int i = 0; i < 18; i++) oe_q.push_back(1'b1);
    end
    @(negedge sys_clk);
    for (int i = 0; i < q.size(); i++) begin
      if (abort > 0 && i == abort) return;
      mdc = 1'b0; mac_oe = oe_q[i]; mac_bit = q[i];
      if (tog && i == hdr + 7) link_up = ~link_up;
      repeat (5) @(negedge sys_clk);
      t_s.push_back(mdio_t);
      o_s.push_back(mdio_i);
      mdc = 1'b1;
      @(negedge sys_clk);
      if (i == hdr) h1 = mdio_t;
      repeat (3) @(negedge sys_clk);
      if (i == hdr) h4 = mdio_t;
      @(negedge sys_clk);
    end
    mac_oe = 1'b0;
    foreach (t_s[i]) if (t_s[i] === 1'b0) ndrv++;
    if (hit && rd) begin
      for (int k = 0; k < 16; k++) word[15-k] = o_s[hdr+2+k];
      chk("ta1_released", t_s[hdr], 1'b1);
      chk("ta2_zero", {t_s[hdr+1], o_s[hdr+1]}, 2'b00);
      chk("drive_periods", ndrv, 17);
      chk("read_data", word, exp);
      chk("turn_on_timing", {h1, h4}, 2'b10);
    end else
      chk("no_drive", drives - d0, 0);
    chk("released_after", mdio_t, 1'b1);
    chk("frame_err_count", errs - e0, (pre >= 32 && !valid_op) ? 1 : 0);
    exp_strobe = hit && !rd && writable(ra);
    chk("strobe_count", strobes - s0, exp_strobe ? 1 : 0);
    if (exp_strobe) begin
      last_wa = ra;
      last_wd = wd;
    end
    chk("wr_addr", wr_addr, last_wa);
    chk("wr_data", wr_data, last_wd);
    if (hit && !rd) begin
      if (ra == 5'd0 && wd[15]) model_reset();
      else if (writable(ra)) m[ra] = wd;
    end
  endtask

  initial begin
    logic [4:0] a;
    logic [15:0] v;
    model_reset();
    repeat (4) @(negedge sys_clk);
    chk("rst_outputs", {mdio_t, mdio_o, wr_strobe, frame_err}, 4'b1000);
    chk("rst_wr_addr", wr_addr, 5'd0);
    chk("rst_wr_data", wr_data, 16'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    frame(2'b10, PA, 5'd2, 16'h0, 32, 0, 0);
    for (int r = 0; r < 32; r++) if (r <= 5 || r == 31) frame(2'b10, PA, 5'(r), 16'h0, 32, 0, 0);
    frame(2'b01, PA, 5'd31, 16'hA5C3, 32, 0, 0);
    frame(2'b10, PA, 5'd31, 16'h0, 32, 0, 0);
    frame(2'b10, 5'd7, 5'd2, 16'h0, 32, 0, 0);
    frame(2'b01, 5'd7, 5'd4, 16'h1234, 32, 0, 0);
    frame(2'b10, PA, 5'd3, 16'h0, 32, 0, 0);
    frame(2'b01, PA, 5'd4, 16'h0BAD, 32, 0, 0);
    frame(2'b01, PA, 5'd4, 16'hFFFF, 31, 0, 0);
    frame(2'b10, PA, 5'd4, 16'h0, 32, 0, 0);
    frame(2'b11, PA, 5'd4, 16'h0, 32, 0, 0);
    frame(2'b00, PA, 5'd4, 16'h0, 32, 0, 0);
    frame(2'b10, PA, 5'd4, 16'h0, 32, 0, 0);
    link_up = 1'b1;
    frame(2'b10, PA, 5'd1, 16'h0, 32, 1, 0);
    frame(2'b10, PA, 5'd1, 16'h0, 32, 0, 0);
    frame(2'b01, PA, 5'd2, 16'h5555, 32, 0, 0);
    frame(2'b01, PA, 5'd9, 16'h5555, 32, 0, 0);
    frame(2'b01, PA, 5'd4, 16'h0000, 32, 0, 0);
    frame(2'b01, PA, 5'd0, 16'h8000, 32, 0, 0);
    frame(2'b10, PA, 5'd4, 16'h0, 32, 0, 0);
    frame(2'b10, PA, 5'd0, 16'h0, 32, 0, 0);
    frame(2'b10, PA, 5'd31, 16'h0, 32, 0, 0);
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 4))
        0: a = 5'd0;
        1: a = 5'd4;
        2: a = 5'd31;
        default: a = 5'($urandom);
      endcase
      v = 16'($urandom);
      if (a == 5'd0 && $urandom_range(0, 3) != 0) v[15] = 1'b0;
      if ($urandom_range(0, 1) == 1) link_up = ~link_up;
      frame($urandom_range(0, 1) == 1 ? 2'b10 : 2'b01, $urandom_range(0, 5) == 0 ? 5'($urandom) : PA,
            a, v, 32, 0, 0);
    end
    frame(2'b01, PA, 5'd31, 16'h1357, 32, 0, 0);
    frame(2'b10, PA, 5'd31, 16'h0, 32, 0, 52);
    chk("driving_mid_read", mdio_t, 1'b0);
    @(negedge sys_clk);
    rst_n = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("rst_release", mdio_t, 1'b1);
    @(negedge sys_clk);
    chk("rst_wr_addr2", wr_addr, 5'd0);
    chk("rst_wr_data2", wr_data, 16'd0);
    mdc = 1'b0;
    mac_oe = 1'b0;
    rst_n = 1'b1;
    model_reset();
    last_wa = '0;
    last_wd = '0;
    repeat (3) @(negedge sys_clk);
    frame(2'b10, PA, 5'd31, 16'h0, 32, 0, 0);
    frame(2'b10, PA, 5'd0, 16'h0, 32, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
